// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-side master for the unified word memory. It takes one RV32I load or
// store request at a time and turns it into memory strobes:
//   - loads read a whole word, then pick out the byte or half-word and
//     sign- or zero-extend it;
//   - stores replicate the data across lanes and write one lane (SB), two
//     single lanes in consecutive cycles (SH), or the full word (SW).
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH (a[0]=1) and LW/SW (a[1:0]!=0) take the
//               error path (no strobe, resp_err=1, response one cycle later)
//   undefined : the low address bits below the access size are ignored and
//               resp_err flags an illegal funct3 only
//
// Parameters
//   ADDR_W            memory word-address width (mem_address = req_addr[ADDR_W+1:2])
//
// Ports
//   clk               clock, all logic on the rising edge
//   rst               synchronous active-high reset
//   req_valid/ready   request handshake, ready only while idle
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I funct3 of the access
//   req_addr          byte address
//   req_wdata         store data (rs2)
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          request was rejected
//   mem_address       word address to memory
//   mem_data_in       lane-replicated store data
//   mem_str, mem_ld   store / load strobes
//   mem_byte_masking  0..3 selects one byte lane, 4'hF selects the whole word
//   mem_data_out      memory read data, valid the cycle after mem_ld
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data_in,
   output logic              mem_str,
   output logic              mem_ld,
   output logic [3:0]        mem_byte_masking,
   input  logic [31:0]       mem_data_out
);

   typedef enum logic [2:0] {
      IDLE,
      LD,
      LDW,
      ST0,
      ST1,
      RESP
   } state_t;

   state_t state;
   state_t state_next;

   logic [2:0]        funct3_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q;

   logic        accept;
   logic        legal;
   logic        misaligned;
   logic        req_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_value;

   // Address bits above the memory are deliberately dropped so accesses wrap.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   assign accept = req_valid && (state == IDLE);

   // Classify the incoming request: legality of funct3 for its direction and,
   // when the trap feature is built in, alignment to the access size.
   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      if (req_we) begin
         legal = (req_funct3 inside {3'b000, 3'b001, 3'b010});
      end else begin
         legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
`ifdef MISALIGN_TRAP_EN
      if (req_funct3[1:0] == 2'b01) begin
         misaligned = req_addr[0];
      end else if (req_funct3[1:0] == 2'b10) begin
         misaligned = (req_addr[1:0] != 2'b00);
      end
`endif
      req_err = !legal || misaligned;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A rejected request skips memory entirely; SH is the
   // only access that needs a second store cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  state_next = RESP;
               end else if (req_we) begin
                  state_next = ST0;
               end else begin
                  state_next = LD;
               end
            end
         end
         LD:      state_next = LDW;
         LDW:     state_next = RESP;
         ST0:     state_next = (funct3_q == 3'b001) ? ST1 : RESP;
         ST1:     state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request fields are captured on accept; the response registers are
   // cleared then so stores and errors always report zero data.
   always_ff @(posedge clk) begin
      if (rst) begin
         funct3_q   <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            funct3_q   <= req_funct3;
            addr_q     <= req_addr[ADDR_W+1:0];
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0;
            resp_err   <= req_err;
         end
         if (state == LDW) begin
            resp_rdata <= load_value;
         end
      end
   end

   // Lane extraction from the returned word, then extension by funct3.
   always_comb begin
      byte_sel   = 8'h00;
      half_sel   = 16'h0000;
      load_value = 32'h0;
      case (addr_q[1:0])
         2'b00:   byte_sel = mem_data_out[7:0];
         2'b01:   byte_sel = mem_data_out[15:8];
         2'b10:   byte_sel = mem_data_out[23:16];
         default: byte_sel = mem_data_out[31:24];
      endcase
      half_sel = addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
      case (funct3_q)
         3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
         3'b010:  load_value = mem_data_out;
         3'b100:  load_value = {24'h0, byte_sel};
         3'b101:  load_value = {16'h0, half_sel};
         default: load_value = 32'h0;
      endcase
   end

   // Handshake and memory-side outputs decoded from state and captured fields.
   // Store data and lane mask are only driven while a store strobe is active.
   // SH writes the lower lane of the selected half in ST0 and the upper in ST1.
   always_comb begin
      req_ready        = (state == IDLE);
      resp_valid       = (state == RESP);
      mem_ld           = (state == LD);
      mem_str          = (state == ST0) || (state == ST1);
      mem_address      = addr_q[ADDR_W+1:2];
      mem_data_in      = 32'h0;
      mem_byte_masking = 4'h0;
      if (mem_str) begin
         case (funct3_q[1:0])
            2'b00: begin
               mem_data_in      = {4{wdata_q[7:0]}};
               mem_byte_masking = {2'b00, addr_q[1:0]};
            end
            2'b01: begin
               mem_data_in      = {2{wdata_q[15:0]}};
               mem_byte_masking = {2'b00, addr_q[1], (state == ST1)};
            end
            2'b10: begin
               mem_data_in      = wdata_q;
               mem_byte_masking = 4'hF;
            end
            default: begin
               mem_data_in      = 32'h0;
               mem_byte_masking = 4'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A word memory with registered read
// and lane-masked write sits on the memory port. Expected results come from a
// byte-addressed reference memory that applies RV32I load/store semantics
// directly (little-endian bytes, arithmetic sign extension).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [11:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_str;
   logic        mem_ld;
   logic [3:0]  mem_byte_masking;
   logic [31:0] mem_data_out = 32'h0;
   logic        mem_clear = 1'b1;

   logic [31:0] mem [0:4095];
   logic [7:0]  ref_mem [0:16383];

   int n_checks = 0;
   int n_pass   = 0;

   int          got_lat, got_ld, got_str, got_strcyc0;
   logic [31:0] got_rdata, got_data0, got_addr0;
   logic        got_err;
   logic [3:0]  got_mask0, got_mask1;

   int          exp_lat, exp_ld, exp_str;
   logic [31:0] exp_rdata;
   logic        exp_err;

   load_store_unit #(.ADDR_W(12)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_err         (resp_err),
      .mem_address      (mem_address),
      .mem_data_in      (mem_data_in),
      .mem_str          (mem_str),
      .mem_ld           (mem_ld),
      .mem_byte_masking (mem_byte_masking),
      .mem_data_out     (mem_data_out)
   );

   always #5 clk = ~clk;

   // Bench memory: registered read on mem_ld, one lane or whole word on mem_str.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      end else begin
         if (mem_ld) mem_data_out <= mem[mem_address];
         if (mem_str) begin
            if (mem_byte_masking == 4'hF) mem[mem_address] <= mem_data_in;
            else mem[mem_address][8*mem_byte_masking[1:0] +: 8] <= mem_data_in[8*mem_byte_masking[1:0] +: 8];
         end
      end
   end

   // Reference: compute the expected response from the RV32I rules over a
   // byte array and apply any store to that array.
   task automatic model_request(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      int unsigned ba, base, nbytes;
      longint      val;
      logic        legal, mis;
      legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
`endif
      exp_err   = !legal || mis;
      exp_rdata = 32'h0;
      exp_ld    = 0;
      exp_str   = 0;
      nbytes    = 1 << f3[1:0];
      ba        = addr & 32'h3FFF;
      base      = ba & ~(nbytes - 1);
      if (exp_err) begin
         exp_lat = 1;
      end else if (!we) begin
         exp_lat = 3;
         exp_ld  = 1;
         val     = 0;
         for (int k = 0; k < nbytes; k++) val = val + (longint'(ref_mem[base+k]) << (8*k));
         if (!f3[2] && nbytes < 4 && val >= (longint'(1) << (8*nbytes - 1))) val = val - (longint'(1) << (8*nbytes));
         exp_rdata = val[31:0];
      end else begin
         exp_lat = (nbytes == 2) ? 3 : 2;
         exp_str = (nbytes == 2) ? 2 : 1;
         for (int k = 0; k < nbytes; k++) ref_mem[base+k] = wdata[8*k +: 8];
      end
   endtask

   // Drive one request, then watch up to 8 cycles for strobes and the response.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      @(posedge clk);
      got_lat = 0; got_ld = 0; got_str = 0; got_strcyc0 = 0; got_err = 1'bx;
      got_rdata = 32'hx; got_data0 = 32'h0; got_addr0 = 32'h0; got_mask0 = 4'h0; got_mask1 = 4'h0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) req_valid = 1'b0;
         if (mem_ld) got_ld++;
         if (mem_str) begin
            if (got_str == 0) begin
               got_strcyc0 = cyc; got_mask0 = mem_byte_masking; got_data0 = mem_data_in; got_addr0 = 32'(mem_address);
            end else begin
               got_mask1 = mem_byte_masking;
            end
            got_str++;
         end
         if (resp_valid) begin
            got_lat = cyc; got_rdata = resp_rdata; got_err = resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_clear = 1'b1;
      for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; mem_clear = 1'b0;
      n_checks++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); else n_pass++;
      n_checks++; if (resp_rdata !== 32'h0) $display("[TB] FAIL reset_resp_rdata: got %h expected 0", resp_rdata); else n_pass++;
      n_checks++; if (resp_err !== 1'b0) $display("[TB] FAIL reset_resp_err: got %b expected 0", resp_err); else n_pass++;
      n_checks++; if (mem_ld !== 1'b0 || mem_str !== 1'b0) $display("[TB] FAIL reset_strobes: got ld=%b str=%b expected 0 0", mem_ld, mem_str); else n_pass++;
      n_checks++; if (mem_address !== 12'h0) $display("[TB] FAIL reset_mem_address: got %h expected 0", mem_address); else n_pass++;
      n_checks++; if (mem_data_in !== 32'h0) $display("[TB] FAIL reset_mem_data_in: got %h expected 0", mem_data_in); else n_pass++;
      n_checks++; if (mem_byte_masking !== 4'h0) $display("[TB] FAIL reset_mask: got %h expected 0", mem_byte_masking); else n_pass++;
      n_checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); else n_pass++;
   endtask

   task automatic test_word();
      applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      model_request(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      n_checks++; if (got_str !== 1 || got_strcyc0 !== 1) $display("[TB] FAIL sw_strobe: got count=%0d cyc=%0d expected 1 1", got_str, got_strcyc0); else n_pass++;
      n_checks++; if (got_addr0 !== 32'd4 || got_mask0 !== 4'hF) $display("[TB] FAIL sw_addr_mask: got addr=%0d mask=%h expected 4 F", got_addr0, got_mask0); else n_pass++;
      n_checks++; if (got_data0 !== 32'hDEADBEEF) $display("[TB] FAIL sw_data: got %h expected DEADBEEF", got_data0); else n_pass++;
      n_checks++; if (got_lat !== 2 || got_err !== 1'b0) $display("[TB] FAIL sw_resp: got lat=%0d err=%b expected 2 0", got_lat, got_err); else n_pass++;
      applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
      model_request(1'b0, 3'b010, 32'h10, 32'h0);
      n_checks++; if (got_lat !== 3 || got_ld !== 1) $display("[TB] FAIL lw_timing: got lat=%0d ld=%0d expected 3 1", got_lat, got_ld); else n_pass++;
      n_checks++; if (got_rdata !== 32'hDEADBEEF) $display("[TB] FAIL lw_rdata: got %h expected DEADBEEF", got_rdata); else n_pass++;
   endtask

   task automatic test_byte();
      applyStimulus(1'b1, 3'b000, 32'h13, 32'hCAFE12A5);
      model_request(1'b1, 3'b000, 32'h13, 32'hCAFE12A5);
      n_checks++; if (got_data0 !== 32'hA5A5A5A5 || got_mask0 !== 4'h3) $display("[TB] FAIL sb_lane: got data=%h mask=%h expected A5A5A5A5 3", got_data0, got_mask0); else n_pass++;
      n_checks++; if (got_lat !== 2 || got_str !== 1) $display("[TB] FAIL sb_timing: got lat=%0d str=%0d expected 2 1", got_lat, got_str); else n_pass++;
      applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
      n_checks++; if (got_rdata !== 32'hFFFFFFA5) $display("[TB] FAIL lb_rdata: got %h expected FFFFFFA5", got_rdata); else n_pass++;
      applyStimulus(1'b0, 3'b100, 32'h13, 32'h0);
      n_checks++; if (got_rdata !== 32'h000000A5) $display("[TB] FAIL lbu_rdata: got %h expected 000000A5", got_rdata); else n_pass++;
   endtask

   task automatic test_half();
      applyStimulus(1'b1, 3'b001, 32'h22, 32'h55558001);
      model_request(1'b1, 3'b001, 32'h22, 32'h55558001);
      n_checks++; if (got_mask0 !== 4'h2 || got_mask1 !== 4'h3 || got_str !== 2) $display("[TB] FAIL sh_masks: got %h %h count=%0d expected 2 3 2", got_mask0, got_mask1, got_str); else n_pass++;
      n_checks++; if (got_data0 !== 32'h80018001) $display("[TB] FAIL sh_data: got %h expected 80018001", got_data0); else n_pass++;
      n_checks++; if (got_lat !== 3) $display("[TB] FAIL sh_latency: got %0d expected 3", got_lat); else n_pass++;
      applyStimulus(1'b0, 3'b001, 32'h22, 32'h0);
      n_checks++; if (got_rdata !== 32'hFFFF8001) $display("[TB] FAIL lh_rdata: got %h expected FFFF8001", got_rdata); else n_pass++;
      applyStimulus(1'b0, 3'b101, 32'h22, 32'h0);
      n_checks++; if (got_rdata !== 32'h00008001) $display("[TB] FAIL lhu_rdata: got %h expected 00008001", got_rdata); else n_pass++;
   endtask

   task automatic test_illegal();
      applyStimulus(1'b0, 3'b011, 32'h10, 32'h0);
      n_checks++; if (got_ld !== 0 || got_str !== 0) $display("[TB] FAIL illegal_load_strobe: got ld=%0d str=%0d expected 0 0", got_ld, got_str); else n_pass++;
      n_checks++; if (got_lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'h0) $display("[TB] FAIL illegal_load_resp: got lat=%0d err=%b rdata=%h expected 1 1 0", got_lat, got_err, got_rdata); else n_pass++;
      applyStimulus(1'b1, 3'b100, 32'h10, 32'h12345678);
      n_checks++; if (got_str !== 0 || got_lat !== 1 || got_err !== 1'b1) $display("[TB] FAIL illegal_store: got str=%0d lat=%0d err=%b expected 0 1 1", got_str, got_lat, got_err); else n_pass++;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         n_checks++; if (req_ready !== 1'b0) $display("[TB] FAIL busy_ready_c%0d: got %b expected 0", cyc, req_ready); else n_pass++;
      end
      n_checks++; if (resp_valid !== 1'b1) $display("[TB] FAIL busy_resp: got %b expected 1", resp_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("[TB] FAIL busy_release: got ready=%b resp=%b expected 1 0", req_ready, resp_valid); else n_pass++;
      req_valid = 1'b0;
   endtask

   task automatic test_misaligned();
      applyStimulus(1'b0, 3'b010, 32'h11, 32'h0);
      model_request(1'b0, 3'b010, 32'h11, 32'h0);
`ifdef MISALIGN_TRAP_EN
      n_checks++; if (got_err !== 1'b1 || got_ld !== 0 || got_lat !== 1) $display("[TB] FAIL misaligned_lw: got err=%b ld=%0d lat=%0d expected 1 0 1", got_err, got_ld, got_lat); else n_pass++;
`else
      n_checks++; if (got_err !== 1'b0 || got_rdata !== 32'hA5ADBEEF) $display("[TB] FAIL misaligned_lw: got err=%b rdata=%h expected 0 A5ADBEEF", got_err, got_rdata); else n_pass++;
`endif
      n_checks++; if (got_rdata !== exp_rdata || got_lat !== exp_lat) $display("[TB] FAIL misaligned_model: got %h/%0d expected %h/%0d", got_rdata, got_lat, exp_rdata, exp_lat); else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h32; req_wdata = 32'h00007E5A; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++; if (mem_str !== 1'b1 || mem_byte_masking !== 4'h2) $display("[TB] FAIL midrst_st0: got str=%b mask=%h expected 1 2", mem_str, mem_byte_masking); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (mem_str !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL midrst_idle: got str=%b resp=%b ready=%b expected 0 0 1", mem_str, resp_valid, req_ready); else n_pass++;
      ref_mem[32'h32] = 8'h5A;
      applyStimulus(1'b0, 3'b101, 32'h32, 32'h0);
      model_request(1'b0, 3'b101, 32'h32, 32'h0);
      n_checks++; if (got_rdata !== 32'h0000005A || got_rdata !== exp_rdata) $display("[TB] FAIL midrst_lane_dropped: got %h expected 0000005A", got_rdata); else n_pass++;
   endtask

   task automatic test_random();
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wdata;
      for (int i = 0; i < 120; i++) begin
         we    = 1'($urandom_range(0, 1));
         addr  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
         wdata = $urandom;
         if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = 3'($urandom_range(0, 2));
         else f3 = 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000);
         if (!we && f3 == 3'b110) f3 = 3'b010;
         applyStimulus(we, f3, addr, wdata);
         model_request(we, f3, addr, wdata);
         n_checks++; if (got_lat !== exp_lat) $display("[TB] FAIL rand_latency #%0d: got %0d expected %0d", i, got_lat, exp_lat); else n_pass++;
         n_checks++; if (got_err !== exp_err) $display("[TB] FAIL rand_err #%0d: got %b expected %b", i, got_err, exp_err); else n_pass++;
         n_checks++; if (got_rdata !== exp_rdata) $display("[TB] FAIL rand_rdata #%0d: got %h expected %h (we=%b f3=%0d a=%h)", i, got_rdata, exp_rdata, we, f3, addr); else n_pass++;
         n_checks++; if (got_ld !== exp_ld || got_str !== exp_str) $display("[TB] FAIL rand_strobes #%0d: got ld=%0d str=%0d expected %0d %0d", i, got_ld, got_str, exp_ld, exp_str); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_illegal();
      test_back_to_back();
      test_misaligned();
      test_reset_mid_op();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
